wb_spi_boot_master: RTL and testbench

//  Wishbone-slave-controlled SPI master: the master end of the PULPino SPI slave link.

---
 rtl/wb_spi_boot_master.sv | 180 ++++++++++++++++++
 tb/tb_wb_spi_boot_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_boot_master.sv
// wb_spi_boot_master: Wishbone-controlled SPI master (mode 0, MSB first,
// one byte per transfer, software chip select) used to push boot/debug
// traffic into the PULPino SPI slave from the Caravel management core.
module wb_spi_boot_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [7:0]  DEFAULT_DIV = 8'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        spi_clk_o,
  output logic        spi_csn_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i,
  output logic        irq_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_CLKDIV = 3'd1;
  localparam logic [2:0] OFF_TX     = 3'd2;
  localparam logic [2:0] OFF_RX     = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        ctrl_cs, ctrl_irq_en;
  logic [7:0]  clkdiv, rx_data, tx_sr, rx_sr, div_cnt;
  logic [2:0]  bit_cnt;
  logic        done, ovr, sclk, sdo, irq, ack;
  logic [31:0] dat, rd_data;
  logic        busy, wb_hit, wb_req, wr_en, rd_en, start;
  logic        tick, rise_tick, fall_tick, xfer_done;
  logic [2:0]  reg_off;
  logic        unused_bits;

  // Handshake: a request is stb&cyc&address-hit; it is accepted on the edge
  // that raises ack (ack <= req & ~ack), so ack is a single-cycle pulse and a
  // held request is answered at most every other cycle. Register side effects
  // and read data capture happen on that same edge.
  assign wb_hit  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wb_req  = wb_hit & ~ack;
  assign wr_en   = wb_req & wbs_we_i & wbs_sel_i[0];
  assign rd_en   = wb_req & ~wbs_we_i;
  assign reg_off = wbs_adr_i[4:2];
  assign busy    = (state_q == ST_SHIFT);
  assign start   = wr_en & (reg_off == OFF_TX) & ~busy;

  assign unused_bits = ^{wbs_dat_i[31:8], wbs_sel_i[3:1], wbs_adr_i[7:5], wbs_adr_i[1:0]};

  assign wbs_ack_o = ack;
  assign wbs_dat_o = dat;
  assign spi_clk_o = sclk;
  assign spi_csn_o = ~ctrl_cs;
  assign spi_sdo_o = sdo;
  assign irq_o     = irq;

  // Register read mux; unmapped offsets (and write-only TXDATA) read as zero.
  always_comb begin
    rd_data = '0;
    case (reg_off)
      OFF_CTRL:   rd_data = {30'd0, ctrl_irq_en, ctrl_cs};
      OFF_CLKDIV: rd_data = {24'd0, clkdiv};
      OFF_RX:     rd_data = {24'd0, rx_data};
      OFF_STATUS: rd_data = {29'd0, ovr, done, busy};
      default:    rd_data = '0;
    endcase
  end

  // Engine next state: half-period ticks while shifting, exit on the 8th falling tick.
  always_comb begin
    state_d   = state_q;
    tick      = 1'b0;
    rise_tick = 1'b0;
    fall_tick = 1'b0;
    xfer_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        tick      = (div_cnt == clkdiv);
        rise_tick = tick & ~sclk;
        fall_tick = tick & sclk;
        if (fall_tick && (bit_cnt == 3'd7)) begin
          xfer_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Bus response: one-cycle ack, read data only visible while ack is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack <= 1'b0;
      dat <= '0;
    end else begin
      ack <= wb_req;
      dat <= rd_en ? rd_data : '0;
    end
  end

  // Control registers and sticky status flags; completion beats a clearing RXDATA read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_cs     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      clkdiv      <= DEFAULT_DIV;
      ovr         <= 1'b0;
      done        <= 1'b0;
      rx_data     <= '0;
      irq         <= 1'b0;
    end else begin
      irq <= done & ctrl_irq_en;
      if (wr_en && reg_off == OFF_CTRL) begin
        ctrl_cs     <= wbs_dat_i[0];
        ctrl_irq_en <= wbs_dat_i[1];
      end
      if (wr_en && reg_off == OFF_CLKDIV && !busy) clkdiv <= wbs_dat_i[7:0];
      if (wr_en && reg_off == OFF_TX && busy) ovr <= 1'b1;
      else if (wr_en && reg_off == OFF_STATUS && wbs_dat_i[2]) ovr <= 1'b0;
      if (xfer_done) begin
        done    <= 1'b1;
        rx_data <= rx_sr;
      end else if (start || (rd_en && reg_off == OFF_RX)) begin
        done <= 1'b0;
      end
    end
  end

  // Shift datapath: sample MISO on rising SCLK, advance MOSI on falling SCLK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
    end else if (start) begin
      tx_sr   <= wbs_dat_i[7:0];
      sdo     <= wbs_dat_i[7];
      sclk    <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (busy) begin
      if (tick) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (rise_tick) rx_sr <= {rx_sr[6:0], spi_sdi_i};
        if (fall_tick && !xfer_done) begin
          tx_sr   <= {tx_sr[6:0], 1'b0};
          sdo     <= tx_sr[6];
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_spi_boot_master.sv
// tb_wb_spi_boot_master: directed + randomized bench for wb_spi_boot_master.
// A mode-0 slave model drives MISO, a monitor records SCLK edges and MOSI bits,
// and expected edge times come from the half-period arithmetic (CLKDIV+1 clk).
module tb_wb_spi_boot_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        spi_clk_o, spi_csn_o, spi_sdo_o, spi_sdi_i, irq_o;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  // Monitor / slave model state
  int          tog_q[$];
  logic        mosi_q[$];
  logic [31:0] exp_q[$];
  int          fall_cnt = 0;
  int          fall_base = 0;
  logic [7:0]  slave_byte = 8'h00;
  logic        sclk_prev = 1'b0;
  logic        irq_prev = 1'b0;
  int          irq_rise = -1;

  wb_spi_boot_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .spi_clk_o (spi_clk_o),
    .spi_csn_o (spi_csn_o),
    .spi_sdo_o (spi_sdo_o),
    .spi_sdi_i (spi_sdi_i),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Record every SCLK toggle with the clk edge that caused it, MOSI at each rise, irq rises.
  always @(negedge clk) begin
    if (spi_clk_o !== sclk_prev) begin
      tog_q.push_back(cyc_n);
      if (spi_clk_o === 1'b1) mosi_q.push_back(spi_sdo_o);
      else fall_cnt = fall_cnt + 1;
      sclk_prev = spi_clk_o;
    end
    if (irq_o === 1'b1 && irq_prev !== 1'b1) irq_rise = cyc_n;
    irq_prev = irq_o;
  end

  // Mode-0 slave: bit 7 ready before the first rise, next bit after each fall.
  always_comb begin
    int k;
    k = fall_cnt - fall_base;
    spi_sdi_i = (k >= 0 && k < 8) ? slave_byte[3'(7 - k)] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one Wishbone access, bounded wait for ack.
  task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic acked, output logic [31:0] rdat,
                          output int lat, output int ack_edge);
    @(posedge clk); #1;
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = sel;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    acked = 1'b0; rdat = 32'h0; lat = -1; ack_edge = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o === 1'b1) begin
        acked = 1'b1; rdat = wbs_dat_o; lat = i + 1; ack_edge = cyc_n;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] data);
    logic ok; logic [31:0] rd; int lat, e;
    wb_cycle(BASE + {27'd0, off}, 1'b1, data, 4'hF, ok, rd, lat, e);
    chk($sformatf("wr_ack_%0h", off), ok, 1'b1);
  endtask

  task automatic rd_chk(input logic [4:0] off, input logic [31:0] exp, input string tag);
    logic ok; logic [31:0] rd; int lat, e;
    wb_cycle(BASE + {27'd0, off}, 1'b0, 32'h0, 4'hF, ok, rd, lat, e);
    chk({tag, "_ack"}, ok, 1'b1);
    chk(tag, rd, exp);
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sl,
                            output int s, output int tbase, output int mbase);
    logic ok; logic [31:0] rd; int lat;
    slave_byte = sl;
    fall_base  = fall_cnt;
    tbase      = tog_q.size();
    mbase      = mosi_q.size();
    wb_cycle(BASE + 32'h8, 1'b1, {24'd0, tx}, 4'hF, ok, rd, lat, s);
    chk("tx_ack", ok, 1'b1);
  endtask

  // Scoreboard: expected toggle k at start + k*(div+1), MOSI byte == tx, final STATUS.
  task automatic finish_xfer(input logic [7:0] tx, input int d, input int s, input int tbase,
                             input int mbase, input logic [31:0] exp_status, input string tag);
    int n = 0;
    int got;
    logic [7:0] mosi_byte = 8'h00;
    while (tog_q.size() < tbase + 16 && n < 16 * (d + 1) + 32) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_toggles"}, tog_q.size() - tbase, 16);
    for (int k = 1; k <= 16; k++) exp_q.push_back(s + k * (d + 1));
    for (int k = 0; k < 16; k++) begin
      got = (tbase + k < tog_q.size()) ? tog_q[tbase + k] : -1;
      chk($sformatf("%s_edge%0d", tag, k), got, exp_q.pop_front());
    end
    for (int i = 0; i < 8; i++)
      mosi_byte = {mosi_byte[6:0], (mbase + i < mosi_q.size()) ? mosi_q[mbase + i] : 1'bx};
    chk({tag, "_mosi"}, mosi_byte, tx);
    chk({tag, "_sclk_idle"}, spi_clk_o, 1'b0);
    chk({tag, "_sdo_hold"}, spi_sdo_o, tx[0]);
    rd_chk(5'h10, exp_status, {tag, "_status"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, tb, mb, d, lat, e, n;
    logic ok;
    logic [31:0] rd;
    logic [7:0] tx, sl;
    logic [3:0] ack_pat;

    // 1: reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_csn", spi_csn_o, 1'b1);
    chk("rst_sclk", spi_clk_o, 1'b0);
    chk("rst_sdo", spi_sdo_o, 1'b0);
    chk("rst_ack", wbs_ack_o, 1'b0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    rd_chk(5'h04, 32'h4, "rst_clkdiv");
    rd_chk(5'h10, 32'h0, "rst_status");
    rd_chk(5'h00, 32'h0, "rst_ctrl");

    // 2: basic byte, CLKDIV=1
    wr(5'h04, 32'h1);
    wr(5'h00, 32'h1);
    chk("t2_csn", spi_csn_o, 1'b0);
    start_xfer(8'hA5, 8'h3C, s, tb, mb);
    finish_xfer(8'hA5, 1, s, tb, mb, 32'h2, "t2");
    rd_chk(5'h0C, 32'h3C, "t2_rx");
    rd_chk(5'h10, 32'h0, "t2_status_after_rx");

    // 3: writes while busy: TX overrun, CLKDIV ignored, cs drop does not stop engine
    sl = 8'($urandom);
    start_xfer(8'h11, sl, s, tb, mb);
    wr(5'h08, 32'h22);
    wr(5'h04, 32'h7);
    wr(5'h00, 32'h0);
    chk("t3_csn_busy", spi_csn_o, 1'b1);
    finish_xfer(8'h11, 1, s, tb, mb, 32'h6, "t3");
    wr(5'h10, 32'h4);
    rd_chk(5'h10, 32'h2, "t3_ovr_clr");
    rd_chk(5'h04, 32'h1, "t3_clkdiv_kept");
    rd_chk(5'h0C, {24'd0, sl}, "t3_rx");
    wr(5'h00, 32'h1);

    // 4: decode and byte-select boundaries
    wb_cycle(32'h3000_0100, 1'b0, 32'h0, 4'hF, ok, rd, lat, e);
    chk("t4_miss_no_ack", ok, 1'b0);
    wb_cycle(BASE + 32'h14, 1'b0, 32'h0, 4'hF, ok, rd, lat, e);
    chk("t4_unmapped_ack", ok, 1'b1);
    chk("t4_unmapped_lat", lat, 1);
    chk("t4_unmapped_dat", rd, 32'h0);
    wb_cycle(BASE + 32'h4, 1'b1, 32'h77, 4'b1110, ok, rd, lat, e);
    chk("t4_sel_ack", ok, 1'b1);
    rd_chk(5'h04, 32'h1, "t4_sel_ignored");
    @(posedge clk); #1;
    wbs_adr_i = BASE + 32'h4; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ack_pat[3 - i] = wbs_ack_o;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    chk("t4_ack_pulses", ack_pat, 4'b1010);

    // 5: interrupt one cycle after done, cleared by RXDATA read
    wr(5'h00, 32'h3);
    sl = 8'($urandom);
    start_xfer(8'hFF, sl, s, tb, mb);
    finish_xfer(8'hFF, 1, s, tb, mb, 32'h2, "t5");
    chk("t5_irq_time", irq_rise, s + 32 + 1);
    chk("t5_irq_high", irq_o, 1'b1);
    wb_cycle(BASE + 32'hC, 1'b0, 32'h0, 4'hF, ok, rd, lat, e);
    chk("t5_rx", rd, {24'd0, sl});
    chk("t5_irq_still", irq_o, 1'b1);
    @(posedge clk); #1;
    chk("t5_irq_clear", irq_o, 1'b0);
    rd_chk(5'h10, 32'h0, "t5_status");
    wr(5'h00, 32'h1);

    // Randomized transfers, first one at the minimum divider
    for (int i = 0; i < 4; i++) begin
      d  = (i == 0) ? 0 : int'($urandom_range(1, 3));
      tx = 8'($urandom);
      sl = 8'($urandom);
      wr(5'h04, 32'(d));
      start_xfer(tx, sl, s, tb, mb);
      finish_xfer(tx, d, s, tb, mb, 32'h2, $sformatf("rnd%0d", i));
      rd_chk(5'h0C, {24'd0, sl}, $sformatf("rnd%0d_rx", i));
    end

    // 6: reset mid-transfer, then a clean transfer
    wr(5'h04, 32'h1);
    start_xfer(8'hF0, 8'h00, s, tb, mb);
    n = 0;
    while (tog_q.size() < tb + 6 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("t6_three_bits", tog_q.size() - tb, 6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_sclk", spi_clk_o, 1'b0);
    chk("t6_csn", spi_csn_o, 1'b1);
    chk("t6_sdo", spi_sdo_o, 1'b0);
    chk("t6_irq", irq_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_chk(5'h10, 32'h0, "t6_status");
    rd_chk(5'h04, 32'h4, "t6_clkdiv");
    wr(5'h00, 32'h1);
    sl = 8'($urandom);
    start_xfer(8'h5A, sl, s, tb, mb);
    finish_xfer(8'h5A, 4, s, tb, mb, 32'h2, "t6");
    rd_chk(5'h0C, {24'd0, sl}, "t6_rx");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
